// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes and forward-select encoding
package alu_pkg;
  localparam int XLEN = 32;
  localparam int RW = 5;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_DIV  = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest in-flight value for one source register, MEM before WB
module fwd_mux #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RW = alu_pkg::RW
) (
  input  logic [RW-1:0]   idx,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_regwrite,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data,
  output logic [1:0]      sel
);
  import alu_pkg::*;
  logic mem_hit, wb_hit;
  assign mem_hit = mem_regwrite && mem_rd != '0 && mem_rd == idx;
  assign wb_hit = wb_regwrite && wb_rd != '0 && wb_rd == idx;
  always_comb begin
    sel = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_REG;
    data = mem_hit ? mem_result : wb_hit ? wb_result : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use detection
module id_ex_stage #(
  parameter int XLEN = alu_pkg::XLEN,
  parameter int RW = alu_pkg::RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [2:0]      id_alu_f,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            mem_regwrite,
  input  logic [RW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [2:0]      ex_f,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memtoreg,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic [1:0]      rs_sel,
  output logic [1:0]      rt_sel,
  output logic            load_use_stall
);
  import alu_pkg::*;
  logic            live, r_alusrc;
  logic [RW-1:0]   r_rs, r_rt;
  logic [XLEN-1:0] r_rs_data, r_rt_data, r_imm, rs_fwd, rt_fwd;
  assign live = id_valid && !flush;
  // a flush loads an all-zero bubble, so it must still open the register when stall is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      r_alusrc    <= 1'b0;
      ex_f        <= '0;
      ex_rd       <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
    end else if (flush || !stall) begin
      ex_valid    <= live;
      ex_regwrite <= live && id_regwrite;
      ex_memtoreg <= live && id_memtoreg;
      ex_memwrite <= live && id_memwrite;
      ex_branch   <= live && id_branch;
      r_alusrc    <= !flush && id_alusrc;
      ex_f        <= flush ? '0 : id_alu_f;
      ex_rd       <= flush ? '0 : id_rd;
      r_rs        <= flush ? '0 : id_rs;
      r_rt        <= flush ? '0 : id_rt;
      r_rs_data   <= flush ? '0 : id_rs_data;
      r_rt_data   <= flush ? '0 : id_rt_data;
      r_imm       <= flush ? '0 : id_imm;
    end
  end
  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs (
    .idx(r_rs), .reg_data(r_rs_data),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rs_fwd), .sel(rs_sel)
  );
  fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rt (
    .idx(r_rt), .reg_data(r_rt_data),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(rt_fwd), .sel(rt_sel)
  );
  assign ex_a = rs_fwd;
  assign ex_b = r_alusrc ? r_imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign load_use_stall = ex_valid && ex_memtoreg && ex_rd != '0 && id_valid
                          && (ex_rd == id_rs || ex_rd == id_rt);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench comparing id_ex_stage against an instruction-level reference model
module tb_id_ex_stage;
  typedef struct packed {
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc;
    logic [2:0]  id_alu_f;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memtoreg, id_memwrite, id_branch;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
  } stim_t;
  typedef struct packed {
    logic        valid, regwrite, memtoreg, memwrite, branch, alusrc;
    logic [2:0]  f;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
  } ent_t;
  typedef struct packed {
    logic [31:0] a, b, store;
    logic [2:0]  f;
    logic [4:0]  rd;
    logic        valid, regwrite, memtoreg, memwrite, branch, lus;
    logic [1:0]  sa, sb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, id_valid, id_alusrc;
  logic [31:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
  logic [2:0]  id_alu_f;
  logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
  logic        id_regwrite, id_memtoreg, id_memwrite, id_branch, mem_regwrite, wb_regwrite;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_f;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch, load_use_stall;
  logic [1:0]  rs_sel, rt_sel;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_alu_f(id_alu_f), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_a(ex_a), .ex_b(ex_b), .ex_f(ex_f), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .rs_sel(rs_sel), .rt_sel(rt_sel),
    .load_use_stall(load_use_stall)
  );

  stim_t cur;
  ent_t  m;
  exp_t  q[$];
  int    compared = 0;
  int    mismatched = 0;

  // reference model: the stage holds one instruction; forwarding picks the youngest writer
  function automatic ent_t capture(input stim_t s);
    ent_t e;
    e.valid    = s.id_valid;
    e.regwrite = s.id_valid & s.id_regwrite;
    e.memtoreg = s.id_valid & s.id_memtoreg;
    e.memwrite = s.id_valid & s.id_memwrite;
    e.branch   = s.id_valid & s.id_branch;
    e.alusrc   = s.id_alusrc;
    e.f        = s.id_alu_f;
    e.rs       = s.id_rs;
    e.rt       = s.id_rt;
    e.rd       = s.id_rd;
    e.rs_data  = s.id_rs_data;
    e.rt_data  = s.id_rt_data;
    e.imm      = s.id_imm;
    return e;
  endfunction

  function automatic logic [1:0] source(input logic [4:0] idx, input stim_t s);
    if (idx == 5'd0) return 2'd0;
    if (s.mem_regwrite && s.mem_rd == idx) return 2'd1;
    if (s.wb_regwrite && s.wb_rd == idx) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] value(input logic [1:0] src, input logic [31:0] own, input stim_t s);
    return src == 2'd1 ? s.mem_result : src == 2'd2 ? s.wb_result : own;
  endfunction

  function automatic exp_t predict(input ent_t e, input stim_t s);
    exp_t x;
    logic [31:0] rt_v;
    x.sa       = source(e.rs, s);
    x.sb       = source(e.rt, s);
    x.a        = value(x.sa, e.rs_data, s);
    rt_v       = value(x.sb, e.rt_data, s);
    x.b        = e.alusrc ? e.imm : rt_v;
    x.store    = rt_v;
    x.f        = e.f;
    x.rd       = e.rd;
    x.valid    = e.valid;
    x.regwrite = e.regwrite;
    x.memtoreg = e.memtoreg;
    x.memwrite = e.memwrite;
    x.branch   = e.branch;
    x.lus      = e.valid && e.memtoreg && e.rd != 0 && s.id_valid && (e.rd == s.id_rs || e.rd == s.id_rt);
    return x;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
    id_rs_data = s.id_rs_data; id_rt_data = s.id_rt_data; id_imm = s.id_imm;
    id_alusrc = s.id_alusrc; id_alu_f = s.id_alu_f;
    id_rs = s.id_rs; id_rt = s.id_rt; id_rd = s.id_rd;
    id_regwrite = s.id_regwrite; id_memtoreg = s.id_memtoreg;
    id_memwrite = s.id_memwrite; id_branch = s.id_branch;
    mem_regwrite = s.mem_regwrite; mem_rd = s.mem_rd; mem_result = s.mem_result;
    wb_regwrite = s.wb_regwrite; wb_rd = s.wb_rd; wb_result = s.wb_result;
  endtask

  // one cycle: advance the model at the edge, drive new inputs, queue the expected view
  task automatic step(input stim_t s);
    @(posedge clk);
    if (cur.rst || cur.flush) m = '0;
    else if (!cur.stall) m = capture(cur);
    #1;
    apply(s);
    cur = s;
    if (s.rst) m = '0;
    q.push_back(predict(m, s));
  endtask

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.id_valid = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst          = $urandom_range(0, 63) == 0;
    s.stall        = $urandom_range(0, 5) == 0;
    s.flush        = $urandom_range(0, 7) == 0;
    s.id_valid     = $urandom_range(0, 3) != 0;
    s.id_rs_data   = $urandom;
    s.id_rt_data   = $urandom;
    s.id_imm       = $urandom;
    s.id_alusrc    = 1'($urandom_range(0, 1));
    s.id_alu_f     = 3'($urandom_range(0, 7));
    s.id_rs        = 5'($urandom_range(0, 7));
    s.id_rt        = 5'($urandom_range(0, 7));
    s.id_rd        = 5'($urandom_range(0, 7));
    s.id_regwrite  = 1'($urandom_range(0, 1));
    s.id_memtoreg  = 1'($urandom_range(0, 1));
    s.id_memwrite  = 1'($urandom_range(0, 1));
    s.id_branch    = 1'($urandom_range(0, 1));
    s.mem_regwrite = 1'($urandom_range(0, 1));
    s.mem_rd       = 5'($urandom_range(0, 7));
    s.mem_result   = $urandom;
    s.wb_regwrite  = 1'($urandom_range(0, 1));
    s.wb_rd        = 5'($urandom_range(0, 7));
    s.wb_result    = $urandom;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ex_a", ex_a, e.a);
      chk("ex_b", ex_b, e.b);
      chk("ex_store_data", ex_store_data, e.store);
      chk("ex_f", 32'(ex_f), 32'(e.f));
      chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_regwrite", 32'(ex_regwrite), 32'(e.regwrite));
      chk("ex_memtoreg", 32'(ex_memtoreg), 32'(e.memtoreg));
      chk("ex_memwrite", 32'(ex_memwrite), 32'(e.memwrite));
      chk("ex_branch", 32'(ex_branch), 32'(e.branch));
      chk("load_use_stall", 32'(load_use_stall), 32'(e.lus));
      chk("rs_sel", 32'(rs_sel), 32'(e.sa));
      chk("rt_sel", 32'(rt_sel), 32'(e.sb));
    end
  end

  initial begin
    stim_t s;
    m = '0;
    cur = base();
    cur.rst = 1'b1;
    apply(cur);
    step(cur);
    for (int i = 0; i < 4; i++) begin
      s = rnd();
      s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0; s.id_valid = 1'b1;
      step(s);
    end
    s = rnd();
    s.rst = 1'b1;
    step(s);
    s = base(); s.id_rs_data = 5; s.id_rt_data = 3; s.id_alu_f = 3'b010;
    s.id_rs = 1; s.id_rt = 2; s.id_rd = 3; s.id_regwrite = 1'b1;
    step(s);
    s = base(); s.stall = 1'b1;
    step(s);
    s = base(); s.id_rs = 4; s.id_rs_data = 32'h77;
    step(s);
    s = base(); s.stall = 1'b1; s.mem_regwrite = 1'b1; s.mem_rd = 4; s.mem_result = 32'h10;
    s.wb_regwrite = 1'b1; s.wb_rd = 4; s.wb_result = 32'h20;
    step(s);
    s.mem_regwrite = 1'b0;
    step(s);
    s = base(); s.id_rs = 0; s.id_rs_data = 0;
    step(s);
    s = base(); s.stall = 1'b1; s.mem_regwrite = 1'b1; s.mem_rd = 0; s.mem_result = 32'hFF;
    step(s);
    s = base(); s.id_alusrc = 1'b1; s.id_imm = 32'hFFFF_FFFC; s.id_rt = 6; s.id_rt_data = 1;
    step(s);
    s = base(); s.stall = 1'b1; s.mem_regwrite = 1'b1; s.mem_rd = 6; s.mem_result = 7;
    step(s);
    s = base(); s.id_memtoreg = 1'b1; s.id_regwrite = 1'b1; s.id_rd = 9;
    step(s);
    s = base(); s.id_rs = 9; s.id_rs_data = 32'hDEAD; s.id_rd = 10; s.id_regwrite = 1'b1; s.flush = 1'b1;
    step(s);
    s.flush = 1'b0;
    step(s);
    s = base(); s.stall = 1'b1; s.wb_regwrite = 1'b1; s.wb_rd = 9; s.wb_result = 32'hCAFE;
    step(s);
    s = base(); s.id_rs = 1; s.id_rs_data = 32'h11; s.id_regwrite = 1'b1; s.id_rd = 2;
    step(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd();
      s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1; s.mem_regwrite = 1'b0; s.wb_regwrite = 1'b0;
      step(s);
    end
    s = rnd(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b1; s.id_valid = 1'b1;
    step(s);
    s = base(); s.stall = 1'b1;
    step(s);
    for (int i = 0; i < 600; i++) step(rnd());
    @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
